// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma keystroke step controller.
// Build option: DOUBLE_STEP_EN selects historical double-stepping in enigma_step_controller.
package enigma_pkg;

    localparam int LETTERS    = 26;
    localparam int NOTCH0_DEF = 16;  // 'Q'
    localparam int NOTCH1_DEF = 4;   // 'E'

    typedef logic [4:0] letter_t;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        ENCODE,
        DONE
    } state_t;

    // Fold a 5-bit value into 0..25; any input is at most 31, so one subtraction suffices.
    function automatic letter_t wrap_letter(input letter_t v);
        return (v > letter_t'(LETTERS - 1)) ? v - letter_t'(LETTERS) : v;
    endfunction

endpackage

// File: rtl/rotor_position_counter.sv
// Mod-26 rotor position register with load, step enable and notch detect.
// Load takes priority over step; at_notch_o reflects the pre-step position.
module rotor_position_counter
    import enigma_pkg::*;
#(
    parameter int NOTCH = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [4:0] load_val_i,
    input  logic       step_i,
    output logic [4:0] pos_o,
    output logic       at_notch_o
);

    letter_t pos_q, pos_d;

    always_comb begin
        // NOTE: default assignment first so every path drives pos_d and no latch is inferred.
        pos_d = pos_q;
        if (load_i) begin
            pos_d = wrap_letter(load_val_i);
        end else if (step_i) begin
            pos_d = (pos_q == letter_t'(LETTERS - 1)) ? '0 : pos_q + 5'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) pos_q <= '0;
        else       pos_q <= pos_d;
    end

    assign pos_o      = pos_q;
    assign at_notch_o = (pos_q == letter_t'(NOTCH));

endmodule

// File: rtl/enigma_step_controller.sv
// Sequences one keystroke: accept, step rotors, wait for datapath settle, present result.
// Build option: define DOUBLE_STEP_EN for historical middle-rotor double-stepping.
module enigma_step_controller
    import enigma_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NOTCH0        = NOTCH0_DEF,
    parameter int NOTCH1        = NOTCH1_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_letter,
    output logic       key_ready,
    input  logic       cfg_load,
    input  logic [4:0] cfg_pos0,
    input  logic [4:0] cfg_pos1,
    input  logic [4:0] cfg_pos2,
    output logic [4:0] pos0,
    output logic [4:0] pos1,
    output logic [4:0] pos2,
    output logic [4:0] dp_letter_out,
    input  logic [4:0] dp_letter_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic       out_err
);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    letter_t    letter_q, letter_d;
    logic       err_q, err_d;
    letter_t    out_letter_q, out_letter_d;
    logic       out_err_q, out_err_d;

    logic accept, load_en, step_en, capture;
    logic step1, step2;
    logic at_notch0, at_notch1, notch2_unused;

    assign accept  = key_valid && key_ready;
    assign load_en = cfg_load && (state_q == IDLE);
    assign step_en = (state_q == STEP) && !err_q;
    assign capture = (state_q == ENCODE) && (cnt_q == 4'(SETTLE_CYCLES - 1));

`ifdef DOUBLE_STEP_EN
    // The middle rotor also steps itself (and carries) whenever it sits on its notch.
    assign step1 = step_en && (at_notch0 || at_notch1);
    assign step2 = step_en && at_notch1;
`else
    assign step1 = step_en && at_notch0;
    assign step2 = step1 && at_notch1;
`endif

    rotor_position_counter #(.NOTCH(NOTCH0)) u_rotor0 (
        .clock(clock), .reset(reset), .load_i(load_en), .load_val_i(cfg_pos0),
        .step_i(step_en), .pos_o(pos0), .at_notch_o(at_notch0)
    );
    rotor_position_counter #(.NOTCH(NOTCH1)) u_rotor1 (
        .clock(clock), .reset(reset), .load_i(load_en), .load_val_i(cfg_pos1),
        .step_i(step1), .pos_o(pos1), .at_notch_o(at_notch1)
    );
    rotor_position_counter #(.NOTCH(0)) u_rotor2 (
        .clock(clock), .reset(reset), .load_i(load_en), .load_val_i(cfg_pos2),
        .step_i(step2), .pos_o(pos2), .at_notch_o(notch2_unused)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = STEP;
            STEP:    state_d = ENCODE;
            ENCODE:  if (capture) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Keystroke and result registers; letter_q stays put from acceptance until the next key.
    always_comb begin
        letter_d     = letter_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        out_letter_d = out_letter_q;
        out_err_d    = out_err_q;
        if (accept) begin
            letter_d = key_letter;
            err_d    = (key_letter > letter_t'(LETTERS - 1));
        end
        if (state_q == STEP)   cnt_d = '0;
        if (state_q == ENCODE) cnt_d = cnt_q + 4'd1;
        if (capture) begin
            out_letter_d = err_q ? '0 : dp_letter_in;
            out_err_d    = err_q;
        end
    end

    // NOTE: every control and output register is reset, so no X escapes after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            letter_q     <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            out_letter_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            letter_q     <= letter_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            out_letter_q <= out_letter_d;
            out_err_q    <= out_err_d;
        end
    end

    assign dp_letter_out = letter_q;
    assign out_letter    = out_letter_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_enigma_step_controller.sv
// Scoreboard bench for enigma_step_controller: a rotor-arithmetic reference model predicts
// each result, a monitor compares on every output handshake.
module tb_enigma_step_controller;

    localparam int SETTLE = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [4:0] key_letter = '0;
    logic       key_ready;
    logic       cfg_load = 1'b0;
    logic [4:0] cfg_pos0 = '0, cfg_pos1 = '0, cfg_pos2 = '0;
    logic [4:0] pos0, pos1, pos2;
    logic [4:0] dp_letter_out, dp_letter_in;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] out_letter;
    logic       out_err;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  dp_tie   = 1'b0;
    bit  bp_en    = 1'b0;
    bit  hold_low = 1'b0;

    typedef struct {
        int letter;
        int err;
        int p0, p1, p2;
        int dp;
    } exp_t;
    exp_t sb[$];

    int m_p0 = 0, m_p1 = 0, m_p2 = 0;

    enigma_step_controller #(.SETTLE_CYCLES(SETTLE)) dut (
        .clock(clock), .reset(reset),
        .key_valid(key_valid), .key_letter(key_letter), .key_ready(key_ready),
        .cfg_load(cfg_load), .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2),
        .pos0(pos0), .pos1(pos1), .pos2(pos2),
        .dp_letter_out(dp_letter_out), .dp_letter_in(dp_letter_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_letter(out_letter), .out_err(out_err)
    );

    always #5 clock = ~clock;

    // Stand-in encode datapath: depends on letter and all three positions.
    function automatic int fake_dp(input int l, input int a, input int b, input int c);
        return (l + a + 3 * b + 7 * c) % 26;
    endfunction

    always_comb dp_letter_in = dp_tie ? 5'd7
        : 5'(fake_dp(int'(dp_letter_out), int'(pos0), int'(pos1), int'(pos2)));

    always @(posedge clock) begin
        #1;
        if (hold_low)   out_ready = 1'b0;
        else if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wrap26(input int v);
        return (v > 25) ? v - 26 : v;
    endfunction

    // Reference model: one keystroke moves the rotors like an odometer with notches Q (16) and E (4).
    function automatic void model_step();
        bit s1, s2;
`ifdef DOUBLE_STEP_EN
        s1 = (m_p0 == 16) || (m_p1 == 4);
        s2 = (m_p1 == 4);
`else
        s1 = (m_p0 == 16);
        s2 = s1 && (m_p1 == 4);
`endif
        m_p0 = (m_p0 + 1) % 26;
        if (s1) m_p1 = (m_p1 + 1) % 26;
        if (s2) m_p2 = (m_p2 + 1) % 26;
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_letter", int'(out_letter), e.letter);
                check("out_err", int'(out_err), e.err);
                check("pos0", int'(pos0), e.p0);
                check("pos1", int'(pos1), e.p1);
                check("pos2", int'(pos2), e.p2);
                check("dp_letter_out", int'(dp_letter_out), e.dp);
            end
        end
    end

    // Offer one key (optionally with a cfg load); returns on the negedge after the handshake.
    task automatic send(input int letter, input bit load, input int c2, input int c1, input int c0);
        int   g = 0;
        exp_t e;
        @(negedge clock);
        while (!key_ready && g < 200) begin
            cfg_load = 1'b1;  // must be ignored while busy
            cfg_pos0 = 5'($urandom);
            cfg_pos1 = 5'($urandom);
            cfg_pos2 = 5'($urandom);
            @(negedge clock);
            g++;
        end
        check("key_ready_timeout", int'(g < 200), 1);
        cfg_load   = load;
        cfg_pos0   = 5'(c0);
        cfg_pos1   = 5'(c1);
        cfg_pos2   = 5'(c2);
        key_valid  = 1'b1;
        key_letter = 5'(letter);
        if (load) begin
            m_p0 = wrap26(c0);
            m_p1 = wrap26(c1);
            m_p2 = wrap26(c2);
        end
        e.err = (letter > 25) ? 1 : 0;
        if (e.err == 0) model_step();
        e.p0 = m_p0;
        e.p1 = m_p1;
        e.p2 = m_p2;
        e.dp = letter;
        e.letter = e.err ? 0 : (dp_tie ? 7 : fake_dp(letter, m_p0, m_p1, m_p2));
        sb.push_back(e);
        @(negedge clock);
        key_valid = 1'b0;
        cfg_load  = 1'b0;
    endtask

    task automatic load_only(input int c2, input int c1, input int c0);
        @(negedge clock);
        check("load_in_idle", int'(key_ready), 1);
        cfg_load = 1'b1;
        cfg_pos0 = 5'(c0);
        cfg_pos1 = 5'(c1);
        cfg_pos2 = 5'(c2);
        m_p0 = wrap26(c0);
        m_p1 = wrap26(c1);
        m_p2 = wrap26(c2);
        @(negedge clock);
        cfg_load = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((!key_ready || sb.size() != 0) && g < 400) begin
            @(negedge clock);
            g++;
        end
        check("idle_timeout", int'(g < 400), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_pos0", int'(pos0), 0);
        check("rst_pos1", int'(pos1), 0);
        check("rst_pos2", int'(pos2), 0);
        check("rst_key_ready", int'(key_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_letter", int'(out_letter), 0);
        check("rst_out_err", int'(out_err), 0);
        check("rst_dp_letter_out", int'(dp_letter_out), 0);

        // Latency with datapath tied to 7
        dp_tie = 1'b1;
        send(0, 1'b0, 0, 0, 0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("latency_cycles", n, SETTLE + 2);
        @(negedge clock);
        check("out_valid_drop", int'(out_valid), 0);
        check("key_ready_back", int'(key_ready), 1);
        dp_tie = 1'b0;
        wait_idle();

        // Loaded starts around the notches and the 25 -> 0 wrap
        send(3, 1'b1, 0, 0, 16);
        send(9, 1'b1, 0, 0, 25);
        send(12, 1'b1, 0, 4, 16);
        wait_idle();
        check("notch_carry_pos2", int'(pos2), 1);
        check("notch_carry_pos1", int'(pos1), 5);
        check("notch_carry_pos0", int'(pos0), 17);

        // Double-step sequence from (0,3,16)
        send(1, 1'b1, 0, 3, 16);
        send(2, 1'b0, 0, 0, 0);
        wait_idle();
`ifdef DOUBLE_STEP_EN
        check("dstep_pos2", int'(pos2), 1);
        check("dstep_pos1", int'(pos1), 5);
`else
        check("dstep_pos2", int'(pos2), 0);
        check("dstep_pos1", int'(pos1), 4);
`endif
        check("dstep_pos0", int'(pos0), 18);

        // Error key and out-of-range configuration
        send(27, 1'b0, 0, 0, 0);
        wait_idle();
        check("err_pos0_unchanged", int'(pos0), 18);
        load_only(31, 26, 28);
        check("cfg_wrap_pos0", int'(pos0), 2);
        check("cfg_wrap_pos1", int'(pos1), 0);
        check("cfg_wrap_pos2", int'(pos2), 5);

        // Back-pressure: result held for 10 cycles
        hold_low = 1'b1;
        send(20, 1'b0, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("hold_reached_done", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_letter", int'(out_letter), sb[0].letter);
            check("hold_key_ready", int'(key_ready), 0);
        end
        hold_low = 1'b0;
        wait_idle();

        // Reset while in ENCODE
        @(negedge clock);
        key_valid  = 1'b1;
        key_letter = 5'd5;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        check("pre_reset_busy", int'(key_ready), 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_p0 = 0;
        m_p1 = 0;
        m_p2 = 0;
        check("encode_rst_key_ready", int'(key_ready), 1);
        check("encode_rst_pos0", int'(pos0), 0);
        check("encode_rst_pos1", int'(pos1), 0);
        check("encode_rst_out_valid", int'(out_valid), 0);
        repeat (SETTLE + 3) @(negedge clock);
        check("encode_rst_no_output", int'(out_valid), 0);

        // Randomized traffic with random back-pressure
        bp_en = 1'b1;
        for (int k = 0; k < 150; k++) begin
            bit ld;
            ld = ($urandom_range(0, 5) == 0);
            send(int'($urandom_range(0, 31)), ld,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end
        wait_idle();
        bp_en = 1'b0;
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
